// File: rtl/ram_loader.sv
// Streams up to DEPTH words into a RAM with one-cycle setup/hold around each
// write pulse, reads them back, and reports whether the read-back sum matches.
module ram_loader #(
  parameter int DEPTH     = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  num_words,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] addr,
  output logic [15:0] bus,
  output logic        ram_write,
  input  logic [15:0] ram_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] checksum,
  output logic [2:0]  fsm_state
);

  // Handshake: a word moves on any rising edge where in_valid && in_ready;
  // in_ready is high only while waiting for the next word.

  typedef enum logic [2:0] {
    IDLE, LOAD_WAIT, SETUP, WRITE, HOLD, RD_ADDR, RD_SAMPLE, FINISH
  } state_t;

  localparam logic [4:0]  DEPTH_W = 5'(DEPTH);
  localparam logic [15:0] BASE    = 16'(BASE_ADDR);

  state_t      state, state_next;
  logic [4:0]  count, idx;
  logic [15:0] wsum, rsum;
  logic [4:0]  nw_sat, idx_inc;
  logic        last;

  assign nw_sat    = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  assign idx_inc   = idx + 5'd1;
  assign last      = (idx_inc == count);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ram_write  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:       if (start) state_next = (nw_sat == 5'd0) ? FINISH : LOAD_WAIT;
      LOAD_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SETUP;
      end
      SETUP:      state_next = WRITE;
      WRITE: begin
        ram_write  = 1'b1;
        state_next = HOLD;
      end
      HOLD:       state_next = last ? RD_ADDR : LOAD_WAIT;
      RD_ADDR:    state_next = RD_SAMPLE;
      RD_SAMPLE:  state_next = last ? FINISH : RD_ADDR;
      FINISH:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // addr/bus only change on a transfer or when stepping the read-back,
  // so they stay stable across SETUP, WRITE and HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      idx      <= '0;
      wsum     <= '0;
      rsum     <= '0;
      addr     <= '0;
      bus      <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      checksum <= '0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            count <= nw_sat;
            idx   <= '0;
            wsum  <= '0;
            rsum  <= '0;
          end
        end
        LOAD_WAIT: begin
          if (in_valid) begin
            bus  <= in_data;
            addr <= BASE + {11'b0, idx};
            wsum <= wsum + in_data;
          end
        end
        HOLD: begin
          if (last) begin
            idx  <= '0;
            addr <= BASE;
          end else begin
            idx  <= idx_inc;
          end
        end
        RD_SAMPLE: begin
          rsum <= rsum + ram_out;
          if (!last) begin
            idx  <= idx_inc;
            addr <= BASE + {11'b0, idx_inc};
          end
        end
        FINISH: begin
          pass     <= (rsum == wsum);
          checksum <= wsum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: small RAM model, write scoreboard, and
// hand-computed sums, latencies and pass flags.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [4:0]  num_words;
  logic [15:0] in_data, addr, bus, ram_out, checksum;
  logic        in_ready, ram_write, busy, done, pass;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int word_idx = 0;
  int n_writes = 0;
  int n_ready = 0;

  logic [31:0] exp_q[$];
  logic [15:0] mem [16];
  logic        corrupt = 1'b0;
  logic [31:0] prev_ab = '0;
  logic        prev_wr = 1'b0;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr(addr), .bus(bus), .ram_write(ram_write), .ram_out(ram_out),
    .busy(busy), .done(done), .pass(pass), .checksum(checksum),
    .fsm_state(fsm_state)
  );

  // RAM model; corrupt forces a wrong read at address 1
  assign ram_out = (corrupt && addr == 16'd1) ? 16'd6 : mem[addr[3:0]];
  always @(posedge clk) if (ram_write) mem[addr[3:0]] <= bus;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard plus setup/hold stability around each write pulse
  always @(negedge clk) begin
    if (ram_write) begin
      n_writes <= n_writes + 1;
      check("setup_stable", {addr, bus}, prev_ab);
      check("write_queued", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) check("write_addr_data", {addr, bus}, exp_q.pop_front());
    end
    if (prev_wr && !rst) check("hold_stable", {addr, bus}, prev_ab);
    if (in_ready) n_ready <= n_ready + 1;
    prev_ab <= {addr, bus};
    prev_wr <= ram_write;
  end

  task automatic start_load(input logic [4:0] n);
    @(negedge clk);
    start     = 1'b1;
    num_words = n;
    t0        = cyc;
    word_idx  = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("in_ready_seen", 32'(got), 32'd1);
    exp_q.push_back({16'(word_idx), d});
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    word_idx++;
  endtask

  task automatic wait_done(input string tag, input int lat, input logic exp_pass,
                           input logic [15:0] exp_sum);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc - t0), 32'(lat));
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w0, r0;
    bit seen_wr;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; num_words = '0;
    #1;
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy_done", {busy, done}, 32'd0);
    check("rst_pass_sum", {15'd0, pass, checksum}, 32'd0);
    check("rst_addr_bus", {addr, bus}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two words, clean read-back
    start_load(5'd2);
    check("busy_loading", 32'(busy), 32'd1);
    feed(16'd9);
    feed(16'd5);
    wait_done("two_words", 14, 1'b1, 16'd14);

    // Read-back corrupted at address 1
    corrupt = 1'b1;
    start_load(5'd2);
    feed(16'd9);
    feed(16'd5);
    wait_done("corrupt", 14, 1'b0, 16'd14);
    corrupt = 1'b0;

    // Zero words: no writes, no in_ready, done two cycles after start
    w0 = n_writes; r0 = n_ready;
    start_load(5'd0);
    wait_done("zero_words", 2, 1'b1, 16'd0);
    check("zero_no_write", 32'(n_writes - w0), 32'd0);
    check("zero_no_ready", 32'(n_ready - r0), 32'd0);

    // Stall in LOAD_WAIT; addr/bus still show the last read-back (addr 1, bus 5)
    start_load(5'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'd1);
      check("stall_no_write", 32'(ram_write), 32'd0);
      check("stall_addr_bus", {addr, bus}, 32'h0001_0005);
      @(negedge clk);
    end
    feed(16'h1234);
    wait_done("stall", 13, 1'b1, 16'h1234);

    // Reset during the WRITE cycle
    start_load(5'd2);
    feed(16'h00A5);
    seen_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ram_write === 1'b1) begin seen_wr = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_write_seen", 32'(seen_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ram_write", 32'(ram_write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr_bus", {addr, bus}, 32'd0);
    check("mid_rst_pass_sum", {15'd0, pass, checksum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    start_load(5'd2);
    feed(16'd3);
    feed(16'd4);
    wait_done("after_reset", 14, 1'b1, 16'd7);

    // Sixteen words of 0xFFFF: sum wraps to 0xFFF0
    start_load(5'd16);
    for (int i = 0; i < 16; i++) feed(16'hFFFF);
    wait_done("full_ffff", 98, 1'b1, 16'hFFF0);

    // Request of 31 words saturates to 16; words 1..16 sum to 0x88
    start_load(5'd31);
    for (int i = 0; i < 16; i++) feed(16'(i + 1));
    wait_done("saturate", 98, 1'b1, 16'h0088);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of RAM words addressable by the loader.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first RAM address written.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a load, sampled in IDLE only.
REQ-006 SHALL have port num_words, input, 5, number of words to load, 0..DEPTH, latched on start.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, 16) and in_ready (output, 1): the word-stream handshake.
REQ-008 SHALL have port addr, output, 16, the RAM address.
REQ-009 SHALL have port bus, output, 16, the RAM write data.
REQ-010 SHALL have port ram_write, output, 1, the RAM write enable.
REQ-011 SHALL have port ram_out, input, 16, the RAM read data (combinational function of addr).
REQ-012 SHALL have ports busy, done, pass (output, 1 each) and checksum (output, 16).

Function
REQ-013 SHALL implement the states IDLE, LOAD_WAIT, SETUP, WRITE, HOLD, RD_ADDR, RD_SAMPLE and FINISH.
REQ-014 SHALL, in IDLE with start=1, latch num_words and clear idx and both sums; go to FINISH if num_words=0, else to LOAD_WAIT.
REQ-015 SHALL assert in_ready only in LOAD_WAIT; a transfer occurs on in_valid&in_ready in the same cycle.
REQ-016 SHALL, on a transfer, register bus<=in_data and addr<=BASE_ADDR+idx, add in_data to wsum (mod 2^16), and go to SETUP.
REQ-017 SHALL, with in_valid=0 in LOAD_WAIT, hold state with ram_write=0 and addr/bus unchanged, for any number of cycles.
REQ-018 SHALL drive ram_write=0 in SETUP, 1 for exactly one cycle in WRITE, and 0 in HOLD.
REQ-019 SHALL hold addr and bus stable throughout SETUP, WRITE and HOLD (setup and hold of one cycle around the write pulse).
REQ-020 SHALL, in HOLD, increment idx; go to RD_ADDR with idx=0 when the incremented idx equals the count, else to LOAD_WAIT.
REQ-021 SHALL take 4 cycles per word (handshake cycle, SETUP, WRITE, HOLD) with in_valid held high.
REQ-022 SHALL drive addr=BASE_ADDR+idx in RD_ADDR with ram_write=0, then in RD_SAMPLE add ram_out to rsum (mod 2^16).
REQ-023 SHALL, after RD_SAMPLE, increment idx and return to RD_ADDR until all words are read, then go to FINISH.
REQ-024 SHALL take 2 cycles per word to read back.
REQ-025 SHALL, in FINISH, register pass<=(rsum==wsum) and checksum<=wsum, pulse done for one cycle, and return to IDLE.
REQ-026 SHALL hold pass and checksum until the next accepted start.
REQ-027 SHALL assert busy in every state except IDLE.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL compute BASE_ADDR+idx modulo 2^16, wrapping from 0xFFFF to 0x0000.
REQ-030 SHALL saturate a num_words value greater than DEPTH to DEPTH.

Reset
REQ-031 SHALL, on rst=1 (asynchronous, including mid-operation), force state IDLE and clear idx, wsum and rsum.
REQ-032 SHALL, on rst=1, drive ram_write=0, in_ready=0, busy=0, done=0, pass=0, checksum=0, addr=0 and bus=0 immediately, without waiting for a clock edge.

Verification
REQ-033 SHALL check: num_words=2, stream 9 then 5, BASE_ADDR=0 -> ram_write pulses with addr=0/bus=9 and addr=1/bus=5, then done pulses with pass=1 and checksum=14.
REQ-034 SHALL check: same load with the RAM model returning 6 at addr 1 -> done pulses with pass=0 and checksum=14.
REQ-035 SHALL check: num_words=0 -> no ram_write and no in_ready, and done pulses 2 cycles after start with pass=1 and checksum=0.
REQ-036 SHALL check: in_valid held low for 5 cycles in LOAD_WAIT -> in_ready=1, ram_write=0, and addr/bus unchanged throughout.
REQ-037 SHALL check: rst asserted during WRITE -> ram_write=0 and busy=0 before the next edge, and a subsequent start works normally.
REQ-038 SHALL check: 16 words of 0xFFFF -> 16 write pulses at addr 0..15, then checksum=0xFFF0 and pass=1.
